// File: rtl/page_table_walker.sv
// Two-level Sv32-style page-table walker sitting between a TLB and a
// word-addressed memory. One walk in flight; every output is a flop.
//
// Handshake rule on all four interfaces: a beat transfers on a rising clk
// edge where valid && ready; a raised valid keeps its payload stable until
// that transfer, and ready may change freely.
module page_table_walker #(
  parameter logic [31:0] ROOT_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req_valid_i,
  output logic        walk_req_ready_o,
  input  logic [19:0] walk_vpn_i,
  output logic        walk_resp_valid_o,
  input  logic        walk_resp_ready_i,
  output logic [19:0] walk_ppn_o,
  output logic        walk_fault_o,
  output logic        walk_super_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_RESP = 3'd2,
    L0_REQ  = 3'd3,
    L0_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic        req_ready_d, resp_valid_d, fault_d, super_d;
  logic        mreq_valid_d, mresp_ready_d;
  logic [19:0] ppn_d;
  logic [31:0] addr_d;

  // PTE fields decoded straight off the response bus; only used on the
  // cycle the response transfers.
  logic pte_v, pte_r, pte_w, pte_x;
  logic pte_bad, pte_leaf, pte_misaligned;
  logic unused_pte_bits;

  assign pte_v          = mem_data_i[0];
  assign pte_r          = mem_data_i[1];
  assign pte_w          = mem_data_i[2];
  assign pte_x          = mem_data_i[3];
  assign pte_bad        = !pte_v || (pte_w && !pte_r);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = (mem_data_i[21:12] != 10'd0);
  assign unused_pte_bits = ^mem_data_i[11:4];

  // Next-state and next-output values; everything holds unless a transfer moves it.
  always_comb begin
    state_d       = state_q;
    vpn0_d        = vpn0_q;
    req_ready_d   = walk_req_ready_o;
    resp_valid_d  = walk_resp_valid_o;
    ppn_d         = walk_ppn_o;
    fault_d       = walk_fault_o;
    super_d       = walk_super_o;
    mreq_valid_d  = mem_req_valid_o;
    addr_d        = mem_addr_o;
    mresp_ready_d = mem_resp_ready_o;
    case (state_q)
      IDLE: begin
        if (walk_req_valid_i && walk_req_ready_o) begin
          vpn0_d       = walk_vpn_i[9:0];
          req_ready_d  = 1'b0;
          mreq_valid_d = 1'b1;
          addr_d       = ROOT_BASE + {20'd0, walk_vpn_i[19:10], 2'b00};
          state_d      = L1_REQ;
        end
      end
      L1_REQ, L0_REQ: begin
        if (mem_req_valid_o && mem_req_ready_i) begin
          mreq_valid_d  = 1'b0;
          mresp_ready_d = 1'b1;
          state_d       = (state_q == L1_REQ) ? L1_RESP : L0_RESP;
        end
      end
      L1_RESP: begin
        if (mem_resp_valid_i && mem_resp_ready_o) begin
          mresp_ready_d = 1'b0;
          if (pte_bad || (pte_leaf && pte_misaligned)) begin
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
            super_d      = 1'b0;
            ppn_d        = 20'd0;
            state_d      = DONE;
          end else if (pte_leaf) begin
            resp_valid_d = 1'b1;
            fault_d      = 1'b0;
            super_d      = 1'b1;
            ppn_d        = {mem_data_i[31:22], vpn0_q};
            state_d      = DONE;
          end else begin
            // Pointer to the level-0 table: index it with VPN0.
            addr_d       = {mem_data_i[31:12], 12'd0} + {20'd0, vpn0_q, 2'b00};
            mreq_valid_d = 1'b1;
            state_d      = L0_REQ;
          end
        end
      end
      L0_RESP: begin
        if (mem_resp_valid_i && mem_resp_ready_o) begin
          mresp_ready_d = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = DONE;
          if (pte_bad || !pte_leaf) begin
            fault_d = 1'b1;
            super_d = 1'b0;
            ppn_d   = 20'd0;
          end else begin
            fault_d = 1'b0;
            super_d = 1'b0;
            ppn_d   = mem_data_i[31:12];
          end
        end
      end
      DONE: begin
        if (walk_resp_valid_o && walk_resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any walk in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      vpn0_q            <= 10'd0;
      walk_req_ready_o  <= 1'b1;
      walk_resp_valid_o <= 1'b0;
      walk_ppn_o        <= 20'd0;
      walk_fault_o      <= 1'b0;
      walk_super_o      <= 1'b0;
      mem_req_valid_o   <= 1'b0;
      mem_addr_o        <= 32'd0;
      mem_resp_ready_o  <= 1'b0;
    end else begin
      state_q           <= state_d;
      vpn0_q            <= vpn0_d;
      walk_req_ready_o  <= req_ready_d;
      walk_resp_valid_o <= resp_valid_d;
      walk_ppn_o        <= ppn_d;
      walk_fault_o      <= fault_d;
      walk_super_o      <= super_d;
      mem_req_valid_o   <= mreq_valid_d;
      mem_addr_o        <= addr_d;
      mem_resp_ready_o  <= mresp_ready_d;
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Bench for page_table_walker: sparse memory model, queued walk requests,
// a reference walker over the memory array and an expected-result queue.
module tb_page_table_walker;

  localparam logic [31:0] ROOT     = 32'h0000_1000;
  localparam logic [31:0] NO_STALL = 32'hFFFF_FFFF;
  localparam logic [21:0] FAULT    = {1'b1, 1'b0, 20'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        walk_req_valid_i = 1'b0;
  logic        walk_req_ready_o;
  logic [19:0] walk_vpn_i = '0;
  logic        walk_resp_valid_o;
  logic        walk_resp_ready_i = 1'b0;
  logic [19:0] walk_ppn_o;
  logic        walk_fault_o;
  logic        walk_super_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i = 1'b0;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i = '0;

  page_table_walker #(.ROOT_BASE(ROOT)) dut (
    .clk(clk), .rst(rst),
    .walk_req_valid_i(walk_req_valid_i), .walk_req_ready_o(walk_req_ready_o),
    .walk_vpn_i(walk_vpn_i),
    .walk_resp_valid_o(walk_resp_valid_o), .walk_resp_ready_i(walk_resp_ready_i),
    .walk_ppn_o(walk_ppn_o), .walk_fault_o(walk_fault_o), .walk_super_o(walk_super_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_data_i(mem_data_i)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: result packed as {fault, super, ppn}.
  logic [21:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [19:0] vpn_q[$];
  logic [31:0] addr_log[$];
  logic [21:0] res_log[$];
  logic [31:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int exp_lat = 0;
  int exp_n = 0;
  int walk_acc = 0;
  int last_acc = 0;
  bit lat_en = 1'b0;
  logic [21:0] last_res = '1;

  // Memory / TLB behaviour knobs: 0 = always ready, 1 = random, 2 = held low.
  int req_mode = 0;
  int wresp_mode = 0;
  int resp_dmax = 0;
  int resp_wait = 0;
  bit mem_busy = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] stall_addr = NO_STALL;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference translation straight from the page-table rules.
  task automatic ref_walk(input logic [19:0] vpn, output logic [21:0] res,
                          output int n, output logic [31:0] a1, output logic [31:0] a0);
    logic [31:0] pte;
    logic v, r, w, x;
    a1 = ROOT + 32'(vpn[19:10]) * 4;
    a0 = '0;
    n = 1;
    pte = rd(a1);
    v = pte[0]; r = pte[1]; w = pte[2]; x = pte[3];
    if (!v || (w && !r)) begin
      res = FAULT;
    end else if (r || x) begin
      if (pte[21:12] != 10'd0) res = FAULT;
      else res = {1'b0, 1'b1, pte[31:22], vpn[9:0]};
    end else begin
      a0 = {pte[31:12], 12'h000} + 32'(vpn[9:0]) * 4;
      n = 2;
      pte = rd(a0);
      v = pte[0]; r = pte[1]; w = pte[2]; x = pte[3];
      if (!v || (w && !r) || !(r || x)) res = FAULT;
      else res = {1'b0, 1'b0, pte[31:12]};
    end
  endtask

  // One clock: note transfers due at the coming edge, cross it, update
  // the models and check invariants, then drive inputs for the next edge.
  task automatic step();
    logic rst_e, mreq_x, mresp_x, wreq_x, wresp_x, pre_mreq_v, pre_wresp_v;
    logic [31:0] pre_addr, a1, a0;
    logic [21:0] pre_res, r;
    logic [19:0] pre_vpn;
    int n;
    rst_e       = rst;
    mreq_x      = !rst && mem_req_valid_o && mem_req_ready_i;
    mresp_x     = !rst && mem_resp_valid_i && mem_resp_ready_o;
    wreq_x      = !rst && walk_req_valid_i && walk_req_ready_o;
    wresp_x     = !rst && walk_resp_valid_o && walk_resp_ready_i;
    pre_mreq_v  = mem_req_valid_o;
    pre_wresp_v = walk_resp_valid_o;
    pre_addr    = mem_addr_o;
    pre_res     = {walk_fault_o, walk_super_o, walk_ppn_o};
    pre_vpn     = walk_vpn_i;
    @(negedge clk);
    cyc++;
    if (rst_e) begin
      exp_q.delete(); exp_addr_q.delete(); vpn_q.delete();
      mem_busy = 1'b0; mem_resp_valid_i = 1'b0; lat_en = 1'b0;
      check("rst_req_ready", 32'(walk_req_ready_o), 32'd1);
      check("rst_ctrl", 32'({walk_resp_valid_o, walk_fault_o, walk_super_o,
                             mem_req_valid_o, mem_resp_ready_o}), 32'd0);
      check("rst_ppn", 32'(walk_ppn_o), 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
    end else begin
      if (wresp_x) begin
        check("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("result", 32'(pre_res), 32'(exp_q.pop_front()));
        check("accesses", 32'(walk_acc), 32'(exp_n));
        exp_addr_q.delete();
        last_res = pre_res;
        last_acc = walk_acc;
        res_log.push_back(pre_res);
      end
      if (wreq_x) begin
        check("accept_when_idle", 32'(exp_q.size()), 32'd0);
        void'(vpn_q.pop_front());
        ref_walk(pre_vpn, r, n, a1, a0);
        exp_q.push_back(r);
        exp_addr_q.push_back(a1);
        if (n == 2) exp_addr_q.push_back(a0);
        exp_n = n;
        exp_lat = 1 + 2 * n;
        lat_en = (req_mode == 0) && (resp_dmax == 0) && (stall_addr == NO_STALL);
        accept_cyc = cyc - 1;
        walk_acc = 0;
        addr_log.delete();
      end
      if (mresp_x) begin
        mem_busy = 1'b0;
        mem_resp_valid_i = 1'b0;
      end
      if (mreq_x) begin
        walk_acc++;
        addr_log.push_back(pre_addr);
        check("mem_req_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) check("mem_addr", pre_addr, exp_addr_q.pop_front());
        mem_busy = 1'b1;
        pend_addr = pre_addr;
        resp_wait = $urandom_range(0, resp_dmax);
      end
      if (pre_mreq_v && !mreq_x) begin
        check("mreq_hold_valid", 32'(mem_req_valid_o), 32'd1);
        check("mreq_hold_addr", mem_addr_o, pre_addr);
      end
      if (pre_wresp_v && !wresp_x)
        check("wresp_hold", 32'({walk_resp_valid_o, walk_fault_o, walk_super_o, walk_ppn_o}),
              32'({1'b1, pre_res}));
      check("resp_ready", 32'(mem_resp_ready_o), 32'(mem_busy));
      check("req_ready", 32'(walk_req_ready_o), 32'(exp_q.size() == 0));
      if (!pre_wresp_v && walk_resp_valid_o && lat_en) begin
        check("latency", 32'(cyc - accept_cyc), 32'(exp_lat));
        lat_en = 1'b0;
      end
    end
    // Drive inputs for the next edge.
    walk_req_valid_i = (vpn_q.size() != 0);
    walk_vpn_i = walk_req_valid_i ? vpn_q[0] : 20'h0;
    walk_resp_ready_i = (wresp_mode == 0) ? 1'b1 :
                        (wresp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_req_ready_i = (req_mode == 0) ? 1'b1 :
                      (req_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mem_req_valid_o && mem_addr_o == stall_addr) mem_req_ready_i = 1'b0;
    if (mem_busy && !mem_resp_valid_i) begin
      if (resp_wait == 0) begin
        mem_resp_valid_i = 1'b1;
        mem_data_i = rd(pend_addr);
      end else begin
        resp_wait--;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || vpn_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    check("wait_done", 32'(exp_q.size() + vpn_q.size()), 32'd0);
    if (exp_q.size() != 0 || vpn_q.size() != 0) do_reset(2);
  endtask

  task automatic run_walk(input logic [19:0] vpn);
    last_res = '1;
    last_acc = -1;
    vpn_q.push_back(vpn);
    wait_idle(200);
  endtask

  // Random page-table entries along the path of one VPN.
  task automatic build_walk(input logic [19:0] vpn);
    logic [31:0] r, l1a, l0a, pte;
    logic [19:0] pg;
    logic [9:0]  mis;
    logic [3:0]  leaf_f[5];
    logic [3:0]  wonly_f[2];
    int k, li, wi;
    leaf_f  = '{4'h3, 4'h7, 4'hB, 4'hF, 4'h9};
    wonly_f = '{4'h5, 4'hD};
    r   = $urandom();
    pg  = 20'($urandom());
    mis = 10'($urandom_range(1, 1023));
    li  = $urandom_range(0, 4);
    wi  = $urandom_range(0, 1);
    l1a = ROOT + 32'(vpn[19:10]) * 4;
    k   = $urandom_range(0, 7);
    case (k)
      0: pte = {r[31:1], 1'b0};
      1: pte = {r[31:4], wonly_f[wi]};
      2: pte = {r[31:22], 10'h0, r[11:4], leaf_f[li]};
      3: pte = {r[31:22], mis, r[11:4], leaf_f[li]};
      default: pte = {pg, r[11:4], 4'h1};
    endcase
    mem[l1a] = pte;
    if (k >= 4) begin
      l0a = {pg, 12'h000} + 32'(vpn[9:0]) * 4;
      r  = $urandom();
      li = $urandom_range(0, 4);
      k  = $urandom_range(0, 5);
      case (k)
        0: pte = {r[31:1], 1'b0};
        1: pte = {r[31:4], wonly_f[wi]};
        2: pte = {r[31:4], 4'h1};
        default: pte = {r[31:4], leaf_f[li]};
      endcase
      mem[l0a] = pte;
    end
  endtask

  initial begin
    int n;
    int nw;
    logic [19:0] v;
    do_reset(3);

    // Two-level walk.
    mem.delete();
    mem[32'h1000] = 32'h0000_2001;
    mem[32'h200C] = 32'h0000_500F;
    run_walk(20'h00003);
    check("two_level_res", 32'(last_res), 32'h0000_0005);
    check("two_level_acc", 32'(last_acc), 32'd2);
    check("two_level_a1", (addr_log.size() > 0) ? addr_log[0] : '1, 32'h1000);
    check("two_level_a0", (addr_log.size() > 1) ? addr_log[1] : '1, 32'h200C);

    // Superpage.
    mem.delete();
    mem[32'h1000] = 32'h0080_000B;
    run_walk(20'h00007);
    check("super_res", 32'(last_res), 32'(22'h10_0807));
    check("super_acc", 32'(last_acc), 32'd1);

    // Level-1 invalid.
    mem.delete();
    mem[32'h1000] = 32'h0000_0000;
    run_walk(20'h00003);
    check("l1_invalid_res", 32'(last_res), 32'(FAULT));
    check("l1_invalid_acc", 32'(last_acc), 32'd1);

    // Misaligned superpage.
    mem[32'h1000] = 32'h0080_100B;
    run_walk(20'h00003);
    check("misaligned_res", 32'(last_res), 32'(FAULT));
    check("misaligned_acc", 32'(last_acc), 32'd1);

    // Level-0 write-without-read.
    mem.delete();
    mem[32'h1000] = 32'h0000_2001;
    mem[32'h200C] = 32'h0000_5005;
    run_walk(20'h00003);
    check("l0_wonly_res", 32'(last_res), 32'(FAULT));
    check("l0_wonly_acc", 32'(last_acc), 32'd2);

    // Backpressure on both the memory request and the walk result.
    mem[32'h200C] = 32'h0000_500F;
    stall_addr = 32'h1000;
    wresp_mode = 2;
    vpn_q.push_back(20'h00003);
    n = 0;
    while (!mem_req_valid_o && n < 20) begin step(); n++; end
    check("bp_req_seen", 32'(mem_req_valid_o), 32'd1);
    repeat (3) begin
      step();
      check("bp_req_valid", 32'(mem_req_valid_o), 32'd1);
      check("bp_req_addr", mem_addr_o, 32'h1000);
      check("bp_busy_ready", 32'(walk_req_ready_o), 32'd0);
    end
    stall_addr = NO_STALL;
    n = 0;
    while (!walk_resp_valid_o && n < 30) begin step(); n++; end
    check("bp_resp_seen", 32'(walk_resp_valid_o), 32'd1);
    repeat (4) begin
      step();
      check("bp_resp_valid", 32'(walk_resp_valid_o), 32'd1);
      check("bp_resp_ppn", 32'(walk_ppn_o), 32'h5);
      check("bp_resp_busy_ready", 32'(walk_req_ready_o), 32'd0);
    end
    wresp_mode = 0;
    wait_idle(50);

    // Back-to-back requests with valid held high.
    mem[32'h2010] = 32'h0000_900B;
    res_log.delete();
    vpn_q.push_back(20'h00003);
    vpn_q.push_back(20'h00004);
    wait_idle(100);
    check("b2b_count", 32'(res_log.size()), 32'd2);
    check("b2b_first", (res_log.size() > 0) ? 32'(res_log[0]) : '1, 32'h5);
    check("b2b_second", (res_log.size() > 1) ? 32'(res_log[1]) : '1, 32'h9);

    // Reset while the level-0 request is waiting.
    stall_addr = 32'h200C;
    vpn_q.push_back(20'h00003);
    n = 0;
    while (!(mem_req_valid_o && mem_addr_o == 32'h200C) && n < 30) begin step(); n++; end
    check("reached_l0_req", 32'({mem_req_valid_o, mem_addr_o == 32'h200C}), 32'd3);
    stall_addr = NO_STALL;
    do_reset(1);
    run_walk(20'h00003);
    check("after_abort_res", 32'(last_res), 32'h5);

    // Randomised page tables, handshake timing and request pairs.
    for (int it = 0; it < 80; it++) begin
      mem.delete();
      req_mode   = $urandom_range(0, 1);
      wresp_mode = $urandom_range(0, 1);
      resp_dmax  = $urandom_range(0, 3);
      nw = $urandom_range(1, 2);
      for (int j = 0; j < nw; j++) begin
        v = 20'($urandom());
        build_walk(v);
        vpn_q.push_back(v);
      end
      wait_idle(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
